// File: rtl/oled_spi_pkg.sv
// Shared definitions for the OLED 4-wire SPI link (CS, DC, SCLK, DIN).
// Used by the receiver, the write master and loopback benches.
// Frame layout is {dc, byte[7:0]} with the DC tag in the top bit.
package oled_spi_pkg;

  // Frame geometry
  localparam int BYTE_W  = 8;
  localparam int FRAME_W = 9;
  localparam int DC_BIT  = 8;

  // Idle levels of the link pins (what a disconnected/idle master presents)
  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_IDLE   = 1'b1;
  localparam logic DC_IDLE   = 1'b0;
  localparam logic DIN_IDLE  = 1'b0;

  // Receiver byte-assembly state
  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_e;

  typedef logic [FRAME_W-1:0] rx_frame_t;

  // Build a received frame from its DC tag and data byte
  function automatic rx_frame_t make_frame(input logic dc, input logic [BYTE_W-1:0] data);
    rx_frame_t f;
    f         = '0;
    f[DC_BIT] = dc;
    f[BYTE_W-1:0] = data;
    return f;
  endfunction

endpackage

// File: rtl/oled_spi_rx_fifo.sv
// First-word-fall-through receive FIFO with occupancy level.
// Latency: push visible on rd_data_o/level_o after the push edge; pop after the pop edge.
// Backpressure: none upstream; push while full is dropped (drop_o) unless a pop lands in the same cycle.
module oled_spi_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);

  // A pop on an empty FIFO is ignored; a pop on a full FIFO frees the slot
  // that a same-cycle push then takes, so level stays at DEPTH.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full || pop_ok);
  assign drop_o  = push_i && full && !pop_ok;

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  // Next pointer and occupancy values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage; cleared on reset so the head reads zero out of reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/oled_spi_rx.sv
// SPI mode-0 slave receiver: oversampled pins -> MSB-first bytes tagged with DC -> FWFT FIFO.
// Latency: byte appears SYNC_STAGES CLK edges after its 8th SCLK rise is first sampled.
// Backpressure: none toward the master; bytes completing into a full FIFO are dropped and flagged.
module oled_spi_rx
  import oled_spi_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          SCLK,
  input  logic                          CS,
  input  logic                          DC,
  input  logic                          DIN,
  input  logic                          RD_EN,
  output logic [FRAME_W-1:0]            RD_DATA,
  output logic                          EMPTY,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          BUSY,
  output logic                          OVERFLOW,
  output logic                          FRAME_ERR,
  input  logic                          CLR_ERR
);

  // Synchronizer chains, oldest stage at the top index
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] dc_sync_q;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic                   sclk_prev_q;

  logic sclk_s;
  logic cs_s;
  logic dc_s;
  logic din_s;
  logic sclk_rise;

  // Byte assembly state
  rx_state_e   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic        push;
  rx_frame_t   push_data;
  logic        frame_evt;

  // FIFO side
  logic        drop;
  logic        overflow_q, overflow_d;
  logic        frame_err_q, frame_err_d;

  // Bring the four pins into the CLK domain, reset to the link idle levels
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
      cs_sync_q   <= {SYNC_STAGES{CS_IDLE}};
      dc_sync_q   <= {SYNC_STAGES{DC_IDLE}};
      din_sync_q  <= {SYNC_STAGES{DIN_IDLE}};
      sclk_prev_q <= SCLK_IDLE;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], DC};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], DIN};
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign dc_s      = dc_sync_q[SYNC_STAGES-1];
  assign din_s     = din_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  // Frame tag is the DC level at the 8th rise only; earlier DC wiggles are ignored
  assign push_data = make_frame(dc_s, {shift_q, din_s});

  // Byte assembly: next state, shift/count update, push and frame-error events
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_evt = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d   = '0;
        shift_d = '0;
        if (!cs_s) begin
          state_d = RX_SHIFT;
        end
      end
      RX_SHIFT: begin
        if (cs_s) begin
          // CS released: any partial byte is discarded and reported
          state_d   = RX_IDLE;
          cnt_d     = '0;
          shift_d   = '0;
          frame_evt = (cnt_q != '0);
        end else if (sclk_rise) begin
          shift_d = {shift_q[5:0], din_s};
          cnt_d   = cnt_q + 1'b1;
          push    = (cnt_q == 3'd7);
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  // Byte assembly registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  oled_spi_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_W)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (RD_EN),
    .rd_data_o   (RD_DATA),
    .empty_o     (EMPTY),
    .level_o     (LEVEL),
    .drop_o      (drop)
  );

  // Sticky error flags: a new event beats a same-cycle clear
  always_comb begin
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    if (CLR_ERR) begin
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
    if (frame_evt) begin
      frame_err_d = 1'b1;
    end
  end

  // Sticky error flag registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign OVERFLOW  = overflow_q;
  assign FRAME_ERR = frame_err_q;
  assign BUSY      = ~cs_s;

endmodule

// File: tb/tb_oled_spi_rx.sv
// Bench for oled_spi_rx: randomized SPI master, queue-based reference model, decoupled pop monitor.
module tb_oled_spi_rx;
  import oled_spi_pkg::*;

  localparam int DEPTH = 4;
  localparam int SS    = 2;

  logic CLK = 1'b0;
  logic RST, SCLK, CS, DC, DIN, RD_EN, CLR_ERR;
  logic [FRAME_W-1:0]      RD_DATA;
  logic                    EMPTY, BUSY, OVERFLOW, FRAME_ERR;
  logic [$clog2(DEPTH):0]  LEVEL;

  int checks = 0;
  int errors = 0;

  // Reference model: what the receive queue should hold, and the flags
  logic [FRAME_W-1:0] exp_q[$];
  bit                 exp_ovf  = 1'b0;
  bit                 exp_ferr = 1'b0;
  int                 frame_bits = 0;

  always #5 CLK = ~CLK;

  oled_spi_rx #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SS)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SCLK      (SCLK),
    .CS        (CS),
    .DC        (DC),
    .DIN       (DIN),
    .RD_EN     (RD_EN),
    .RD_DATA   (RD_DATA),
    .EMPTY     (EMPTY),
    .LEVEL     (LEVEL),
    .BUSY      (BUSY),
    .OVERFLOW  (OVERFLOW),
    .FRAME_ERR (FRAME_ERR),
    .CLR_ERR   (CLR_ERR)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // A completed byte lands in the queue if there is room, otherwise it is lost
  task automatic model_push(input logic [FRAME_W-1:0] e);
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else exp_ovf = 1'b1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_level"},    32'(LEVEL),     32'(exp_q.size()));
    check({tag, "_empty"},    32'(EMPTY),     32'(exp_q.size() == 0));
    check({tag, "_overflow"}, 32'(OVERFLOW),  32'(exp_ovf));
    check({tag, "_frame_err"},32'(FRAME_ERR), 32'(exp_ferr));
  endtask

  // Mode-0 master: data changes with SCLK low, sampled on rise; SCLK = CLK/8
  task automatic send_bits(input logic [7:0] b, input int nbits, input logic dc,
                           input bit noise, input bit lat, input bit pop_last);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      DIN  = b[7-i];
      DC   = (i == 7) ? dc : (noise ? 1'($urandom_range(0, 1)) : dc);
      repeat (4) tick();
      SCLK = 1'b1;
      if (i == 7) begin
        tick();
        if (lat) check("lat_edge_n", 32'(EMPTY), 32'd1);
        tick();
        if (lat) check("lat_edge_n1", 32'(EMPTY), 32'd1);
        if (pop_last) RD_EN = 1'b1;
        tick();
        if (lat) check("lat_edge_n2", 32'(EMPTY), 32'd0);
        RD_EN = 1'b0;
        tick();
      end else begin
        repeat (4) tick();
      end
    end
    SCLK = 1'b0;
    frame_bits += nbits;
    if (nbits == 8) model_push({dc, b});
  endtask

  task automatic cs_begin();
    CS = 1'b0;
    repeat (2) tick();
  endtask

  task automatic cs_end();
    SCLK = 1'b0;
    CS   = 1'b1;
    if (frame_bits % 8 != 0) exp_ferr = 1'b1;
    frame_bits = 0;
    repeat (4) tick();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 2 && !EMPTY; i++) begin
      RD_EN = 1'b1;
      tick();
      RD_EN = 1'b0;
    end
    check({tag, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_drain_empty"}, 32'(EMPTY), 32'd1);
  endtask

  task automatic pulse_clr();
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
  endtask

  // Monitor: whenever the DUT is about to pop, its head must match the model head
  initial begin
    logic [FRAME_W-1:0] e;
    forever begin
      @(negedge CLK);
      if (RD_EN === 1'b1 && EMPTY === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got %0h expected no entry", RD_DATA);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", 32'(RD_DATA), 32'(e));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] rb;
    logic       rdc;
    int         n;

    RST = 1'b1; SCLK = 1'b0; CS = 1'b1; DC = 1'b0; DIN = 1'b0;
    RD_EN = 1'b0; CLR_ERR = 1'b0;
    repeat (3) tick();
    check("rst_rd_data", 32'(RD_DATA), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check_status("rst");
    RST = 1'b0;
    tick();
    check_status("post_rst");

    // Single command byte with latency and BUSY lag
    CS = 1'b0;
    tick();
    check("busy_lag", 32'(BUSY), 32'd0);
    tick();
    check("busy_set", 32'(BUSY), 32'd1);
    send_bits(8'hAE, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    check_status("ae");
    check("ae_head", 32'(RD_DATA), 32'h0AE);
    cs_end();
    check("busy_clear", 32'(BUSY), 32'd0);
    drain("ae");

    // Two bytes under one CS, DC noise on bits 1-7
    cs_begin();
    send_bits(8'h81, 8, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bits(8'h7F, 8, 1'b1, 1'b1, 1'b0, 1'b0);
    cs_end();
    check_status("pair");
    drain("pair");

    // Random frames
    for (int f = 0; f < 6; f++) begin
      cs_begin();
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        rb  = 8'($urandom);
        rdc = 1'($urandom_range(0, 1));
        send_bits(rb, 8, rdc, 1'b1, 1'b0, 1'b0);
      end
      cs_end();
      check_status("rand");
      drain("rand");
    end

    // Overflow: five bytes, no reads
    cs_begin();
    for (int k = 0; k < 5; k++) begin
      rb = 8'($urandom);
      send_bits(rb, 8, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end
    cs_end();
    check_status("ovf");
    pulse_clr();
    check_status("ovf_clr");
    drain("ovf");

    // Five bytes with a read landing on the 5th push
    cs_begin();
    for (int k = 0; k < 5; k++) begin
      rb = 8'($urandom);
      send_bits(rb, 8, 1'($urandom_range(0, 1)), 1'b0, 1'b0, k == 4);
    end
    cs_end();
    check_status("full_pop");
    drain("full_pop");

    // CS released mid-byte, then a clean byte
    cs_begin();
    send_bits(8'($urandom), 5, 1'b0, 1'b0, 1'b0, 1'b0);
    cs_end();
    check_status("ferr");
    cs_begin();
    send_bits(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    cs_end();
    check_status("ferr_next");
    check("ferr_head", 32'(RD_DATA), 32'h03C);
    drain("ferr");
    pulse_clr();
    check_status("ferr_clr");

    // Reset in the middle of a byte with entries queued, CS held low
    cs_begin();
    send_bits(8'($urandom), 8, 1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(8'($urandom), 8, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'($urandom), 4, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_level", 32'(LEVEL), 32'd2);
    RST = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0; exp_ferr = 1'b0; frame_bits = 0;
    repeat (2) tick();
    check_status("mid_rst");
    check("mid_rst_rd_data", 32'(RD_DATA), 32'd0);
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    RST = 1'b0;
    repeat (SS + 2) tick();
    send_bits(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_a5_head", 32'(RD_DATA), 32'h1A5);
    cs_end();
    check_status("rst_a5");
    drain("rst_a5");

    // SCLK activity with CS high, then a read while empty
    CS = 1'b1;
    for (int k = 0; k < 8; k++) begin
      SCLK = 1'b0; DIN = 1'($urandom_range(0, 1));
      repeat (4) tick();
      SCLK = 1'b1;
      repeat (4) tick();
    end
    SCLK = 1'b0;
    repeat (4) tick();
    check("cs_high_busy", 32'(BUSY), 32'd0);
    check_status("cs_high");
    RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0;
    tick();
    check_status("rd_empty");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oled_spi_rx.md
# oled_spi_rx

SPI mode-0 slave receiver for the OLED 4-wire link (CS, DC, SCLK, DIN): the receiving end of the team's SPI write master. It oversamples the serial pins in the system clock domain, assembles MSB-first bytes tagged with their DC bit, and queues them in a small first-word-fall-through FIFO. Used as the display-side model in loopback benches and as a link monitor/sniffer in the FPGA.

## Interface
Parameters:
- FIFO_DEPTH, 4, entries in receive FIFO; power of two, ≥2
- SYNC_STAGES, 2, synchronizer flops per input pin; ≥2

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- SCLK  in  1  serial clock from master; asynchronous to CLK
- CS  in  1  chip select, active low
- DC  in  1  data(1)/command(0)
- DIN  in  1  serial data, MSB first
- RD_EN  in  1  pop head entry when EMPTY=0
- RD_DATA  out  9  head entry {dc, byte[7:0]}; valid while EMPTY=0
- EMPTY  out  1  FIFO empty
- LEVEL  out  $clog2(FIFO_DEPTH)+1  entries held
- BUSY  out  1  synchronized CS is low
- OVERFLOW  out  1  sticky: completed byte dropped, FIFO full
- FRAME_ERR  out  1  sticky: CS released mid-byte
- CLR_ERR  in  1  clears OVERFLOW and FRAME_ERR

## Operation
- SCLK, CS, DC, DIN each pass through SYNC_STAGES flops; one extra SCLK flop gives rise = sync & ~prev. Sync reset values: SCLK 0, CS 1, DC 0, DIN 0.
- Receiver states: IDLE (sync CS=1), SHIFT (sync CS=0). IDLE→SHIFT when sync CS=0; SHIFT→IDLE when sync CS=1.
- IDLE: bit counter (3 bits) and shift register held at 0; SCLK rises ignored.
- SHIFT, on rise: shift in sync DIN at LSB, counter+1. On the rise taking counter 7→0, push {sync DC, shift[6:0], DIN} — DC sampled at the 8th bit only. Counter wraps; consecutive bytes under one CS low are supported.
- SHIFT→IDLE with counter ≠0: FRAME_ERR set, partial byte discarded. Counter = 0: no error.
- FIFO: FWFT; RD_DATA = head entry combinationally. RD_EN with EMPTY=1 ignored, no underflow.
- Push with FIFO full: if RD_EN in same cycle, push accepted and head popped (LEVEL unchanged); else byte dropped, OVERFLOW set, contents untouched.
- Simultaneous push and pop when not full/empty: LEVEL unchanged.
- CLR_ERR clears both sticky flags; an error event in the same cycle wins (flag stays 1).
- Pointers wrap modulo FIFO_DEPTH; LEVEL counts 0..FIFO_DEPTH.

## Timing
- Reset values: RD_DATA 0 (storage cleared), EMPTY 1, LEVEL 0, BUSY 0, OVERFLOW 0, FRAME_ERR 0; state IDLE, counter 0.
- RST mid-byte or mid-frame: everything returns to reset values, partial and queued data lost; after release, reception resumes at the next CS low (a CS already low resumes at bit 0).
- Latency: 8th SCLK rising edge first sampled high at CLK edge N → EMPTY=0, LEVEL+1 and RD_DATA valid after edge N+SYNC_STAGES (N+2 with defaults).
- BUSY follows pin CS with SYNC_STAGES cycles delay.
- Pop: RD_EN high at edge M → LEVEL−1 and next head on RD_DATA after edge M.
- Input requirement: SCLK high and low each ≥3 CLK periods; DIN/DC stable ≥1 CLK before and after SCLK rise; CS low ≥1 CLK before the first SCLK rise. Violations are unsupported, not detected.

## Structure
- Package oled_spi_pkg: FRAME_W=9, DC_BIT=8, BYTE_W=8, pin idle-level constants; shared with the SPI write master and benches.
- One sub-module: oled_spi_rx_fifo (FWFT FIFO with LEVEL, full/empty, push-and-pop-when-full handling). Synchronizers and shift FSM stay in the top.

## Test plan
- Master sends CS=0, DC=0, byte 0xAE (mode 0, SCLK = CLK/8) → one entry 0x0AE, LEVEL=1, no flags; EMPTY falls exactly SYNC_STAGES edges after 8th SCLK rise is sampled.
- Under one CS low send 0x81 (DC=0) then 0x7F (DC=1) → entries 0x081, 0x17F in order; DC changing during bits 1–7 does not affect the tag.
- Send 5 bytes with no reads, FIFO_DEPTH=4 → LEVEL=4, OVERFLOW=1, entries are bytes 1–4; CLR_ERR → OVERFLOW=0; repeat with RD_EN pulsed on the 5th push cycle → all five received, no overflow.
- Raise CS after 5 bits, then send 0x3C → FRAME_ERR=1, only 0x03C queued (no residue of the partial byte).
- Assert RST after 4 bits of a byte with 2 entries queued → EMPTY=1, LEVEL=0, RD_DATA=0, flags 0; next full byte 0xA5 (DC=1) gives 0x1A5.
- SCLK toggling with CS=1 → LEVEL stays 0, BUSY=0; RD_EN while empty → no LEVEL change.
